// File: rtl/rx_cu.sv
// rx_cu - JESD204 receive-side link control unit.
//
// Runs one code-group-synchronisation FSM per lane on decoded 8b/10b
// characters, drives SYNC (released on a local LMFC boundary), tracks the
// initial lane alignment sequence per lane and enables the data path.
//
// Optional feature: define RX_CU_ILA_TIMEOUT_EN to abandon ILA and fall back
// to CGS after ILA_TO LMFC periods without every lane completing ILA.
//
// Ports:
//   CLK          clock
//   RST          synchronous active-high reset
//   RX_DATA      decoded octet per lane, lane i at [8i+7:8i]
//   RX_K         control-character flag per lane
//   RX_ERR       disparity / not-in-table error per lane
//   LMFC_ME      one-cycle pulse at local multiframe end
//   SYNC         high = link synchronised (release request to TX)
//   ILA_EN       high while ILA is being received
//   DATA_EN      high in DATA phase
//   LANE_SYNCED  per-lane CGS state != CS_INIT
module rx_cu #(
   parameter int L      = 4,
   parameter int ILA_MF = 4,
   parameter int ILA_TO = 8
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [8*L-1:0] RX_DATA,
   input  logic [L-1:0]   RX_K,
   input  logic [L-1:0]   RX_ERR,
   input  logic           LMFC_ME,
   output logic           SYNC,
   output logic           ILA_EN,
   output logic           DATA_EN,
   output logic [L-1:0]   LANE_SYNCED
);

   localparam int AW = $clog2(ILA_MF + 1);

   localparam logic [7:0] CH_K = 8'hBC;
   localparam logic [7:0] CH_R = 8'h1C;
   localparam logic [7:0] CH_A = 8'h7C;

   if (L < 1 || ILA_MF < 1 || ILA_TO < 1) begin : g_param_check
      $error("rx_cu: L, ILA_MF and ILA_TO must all be at least 1");
   end

   typedef enum logic [1:0] {CS_INIT, CS_CHECK, CS_DATA} cs_t;
   typedef enum logic [1:0] {G_IDLE, G_CGS, G_ILA, G_DATA} gs_t;

   function automatic logic is_char(input logic [7:0] d, input logic k,
                                    input logic [7:0] code);
      return k && (d == code);
   endfunction

   cs_t            cs       [L];
   cs_t            cs_nxt   [L];
   logic [1:0]     kcnt     [L];
   logic [1:0]     kcnt_nxt [L];
   logic [1:0]     err_cnt  [L];
   logic [1:0]     err_nxt  [L];
   logic [1:0]     good_run [L];
   logic [1:0]     good_nxt [L];
   logic           seen_r   [L];
   logic           seen_nxt [L];
   logic [AW-1:0]  a_cnt    [L];
   logic [AW-1:0]  a_nxt    [L];
   logic [L-1:0]   lane_drop;
   logic [L-1:0]   lane_done;
   gs_t            g_state, g_nxt;

   // Per-lane CGS and ILA next-state logic
   always_comb begin
      for (int i = 0; i < L; i++) begin
         cs_nxt[i]   = cs[i];
         kcnt_nxt[i] = kcnt[i];
         err_nxt[i]  = err_cnt[i];
         good_nxt[i] = good_run[i];
         seen_nxt[i] = seen_r[i];
         a_nxt[i]    = a_cnt[i];

         case (cs[i])
            CS_INIT: begin
               if (is_char(RX_DATA[8*i +: 8], RX_K[i], CH_K) && !RX_ERR[i]) begin
                  if (kcnt[i] == 2'd3) begin
                     cs_nxt[i]   = CS_CHECK;
                     kcnt_nxt[i] = 2'd0;
                     err_nxt[i]  = 2'd0;
                     good_nxt[i] = 2'd0;
                  end else begin
                     kcnt_nxt[i] = kcnt[i] + 2'd1;
                  end
               end else begin
                  kcnt_nxt[i] = 2'd0;
               end
            end
            default: begin
               if (RX_ERR[i]) begin
                  good_nxt[i] = 2'd0;
                  // Third outstanding error loses code-group sync.
                  if (err_cnt[i] == 2'd2) begin
                     cs_nxt[i]   = CS_INIT;
                     kcnt_nxt[i] = 2'd0;
                     err_nxt[i]  = 2'd0;
                  end else begin
                     err_nxt[i] = err_cnt[i] + 2'd1;
                  end
               end else begin
                  if (cs[i] == CS_CHECK && !is_char(RX_DATA[8*i +: 8], RX_K[i], CH_K))
                     cs_nxt[i] = CS_DATA;
                  // Four consecutive good characters forgive one error.
                  if (err_cnt[i] != 2'd0) begin
                     if (good_run[i] == 2'd3) begin
                        err_nxt[i]  = err_cnt[i] - 2'd1;
                        good_nxt[i] = 2'd0;
                     end else begin
                        good_nxt[i] = good_run[i] + 2'd1;
                     end
                  end
               end
            end
         endcase

         if (g_state != G_ILA) begin
            seen_nxt[i] = 1'b0;
            a_nxt[i]    = '0;
         end else if (a_cnt[i] != AW'(ILA_MF) && !RX_ERR[i]) begin
            if (is_char(RX_DATA[8*i +: 8], RX_K[i], CH_R))
               seen_nxt[i] = 1'b1;
            // /A/ only counts once /R/ has marked the start of ILA.
            if (is_char(RX_DATA[8*i +: 8], RX_K[i], CH_A) && seen_r[i])
               a_nxt[i] = a_cnt[i] + AW'(1);
         end

         // Look at next state so the global FSM reacts on the same edge.
         lane_drop[i] = (cs_nxt[i] == CS_INIT);
         lane_done[i] = (a_nxt[i] == AW'(ILA_MF));
      end
   end

`ifdef RX_CU_ILA_TIMEOUT_EN
   localparam int TW = $clog2(ILA_TO + 1);
   logic [TW-1:0] to_cnt;
   logic          ila_timeout;

   assign ila_timeout = LMFC_ME && (to_cnt == TW'(ILA_TO - 1));

   always_ff @(posedge CLK) begin
      if (RST || g_state != G_ILA)
         to_cnt <= '0;
      else if (LMFC_ME)
         to_cnt <= to_cnt + TW'(1);
   end
`endif

   // Global link FSM next state
   always_comb begin
      g_nxt = g_state;
      case (g_state)
         G_IDLE: g_nxt = G_CGS;
         G_CGS: begin
            if ((&LANE_SYNCED) && LMFC_ME && !(|lane_drop))
               g_nxt = G_ILA;
         end
         G_ILA: begin
            if (|lane_drop)
               g_nxt = G_CGS;
            else if (&lane_done)
               g_nxt = G_DATA;
`ifdef RX_CU_ILA_TIMEOUT_EN
            else if (ila_timeout)
               g_nxt = G_CGS;
`endif
         end
         G_DATA: begin
            if (|lane_drop)
               g_nxt = G_CGS;
         end
         default: g_nxt = G_IDLE;
      endcase
   end

   // State registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         g_state <= G_IDLE;
         for (int i = 0; i < L; i++) begin
            cs[i]       <= CS_INIT;
            kcnt[i]     <= 2'd0;
            err_cnt[i]  <= 2'd0;
            good_run[i] <= 2'd0;
            seen_r[i]   <= 1'b0;
            a_cnt[i]    <= '0;
         end
      end else begin
         g_state <= g_nxt;
         for (int i = 0; i < L; i++) begin
            cs[i]       <= cs_nxt[i];
            kcnt[i]     <= kcnt_nxt[i];
            err_cnt[i]  <= err_nxt[i];
            good_run[i] <= good_nxt[i];
            seen_r[i]   <= seen_nxt[i];
            a_cnt[i]    <= a_nxt[i];
         end
      end
   end

   // Moore output decode
   always_comb begin
      SYNC    = (g_state == G_ILA) || (g_state == G_DATA);
      ILA_EN  = (g_state == G_ILA);
      DATA_EN = (g_state == G_DATA);
      for (int i = 0; i < L; i++)
         LANE_SYNCED[i] = (cs[i] != CS_INIT);
   end

endmodule

// File: tb/tb_rx_cu.sv
// tb_rx_cu - directed testbench for rx_cu (L=4, ILA_MF=4, ILA_TO=8).
module tb_rx_cu;
   localparam int L = 4;
   localparam logic [7:0] K_CH = 8'hBC;
   localparam logic [7:0] R_CH = 8'h1C;
   localparam logic [7:0] A_CH = 8'h7C;

   logic           CLK = 1'b0;
   logic           RST;
   logic [8*L-1:0] RX_DATA;
   logic [L-1:0]   RX_K;
   logic [L-1:0]   RX_ERR;
   logic           LMFC_ME;
   logic           SYNC;
   logic           ILA_EN;
   logic           DATA_EN;
   logic [L-1:0]   LANE_SYNCED;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   rx_cu #(.L(L), .ILA_MF(4), .ILA_TO(8)) dut (
      .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_K(RX_K), .RX_ERR(RX_ERR),
      .LMFC_ME(LMFC_ME), .SYNC(SYNC), .ILA_EN(ILA_EN), .DATA_EN(DATA_EN),
      .LANE_SYNCED(LANE_SYNCED)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic s, input logic ila,
                          input logic dat, input logic [L-1:0] ls);
      chk({tag, ".SYNC"}, 32'(SYNC), 32'(s));
      chk({tag, ".ILA_EN"}, 32'(ILA_EN), 32'(ila));
      chk({tag, ".DATA_EN"}, 32'(DATA_EN), 32'(dat));
      chk({tag, ".LANE_SYNCED"}, 32'(LANE_SYNCED), 32'(ls));
   endtask

   task automatic set_lane(input int i, input logic [7:0] d, input logic k);
      RX_DATA[8*i +: 8] = d;
      RX_K[i] = k;
   endtask

   task automatic set_all(input logic [7:0] d, input logic k);
      for (int i = 0; i < L; i++) set_lane(i, d, k);
   endtask

   initial begin
      RST = 1'b1; RX_DATA = '0; RX_K = '0; RX_ERR = '0; LMFC_ME = 1'b0;
      tick(); tick();
      chk_out("reset", 1'b0, 1'b0, 1'b0, 4'h0);
      RST = 1'b0;

      // Lane 0: /K/ x3, 0x55, /K/ x4; other lanes idle data
      set_lane(0, K_CH, 1'b1);
      tick(); chk("k1", 32'(LANE_SYNCED), 32'h0);
      tick(); tick(); chk("k3", 32'(LANE_SYNCED), 32'h0);
      set_lane(0, 8'h55, 1'b0);
      tick(); chk("k_break", 32'(LANE_SYNCED), 32'h0);
      set_lane(0, K_CH, 1'b1);
      tick(); tick(); tick(); chk("k3_again", 32'(LANE_SYNCED), 32'h0);
      tick(); chk_out("k4_lane0", 1'b0, 1'b0, 1'b0, 4'h1);

      // All lanes /K/; LMFC withheld keeps SYNC low
      set_all(K_CH, 1'b1);
      tick(); tick(); tick(); chk("all_k3", 32'(LANE_SYNCED), 32'h1);
      tick(); chk("all_k4", 32'(LANE_SYNCED), 32'hF);
      tick(); tick(); chk_out("no_lmfc", 1'b0, 1'b0, 1'b0, 4'hF);
      LMFC_ME = 1'b1; tick(); LMFC_ME = 1'b0;
      chk_out("ila_entry", 1'b1, 1'b1, 1'b0, 4'hF);

      // ILA: lane 2 sends /A/ before /R/, which must not count
      set_lane(0, R_CH, 1'b1); set_lane(1, R_CH, 1'b1);
      set_lane(2, A_CH, 1'b1); set_lane(3, R_CH, 1'b1); tick();
      set_all(A_CH, 1'b1); set_lane(2, R_CH, 1'b1); tick();
      set_all(A_CH, 1'b1); tick(); tick(); tick();
      chk_out("early_a_ignored", 1'b1, 1'b1, 1'b0, 4'hF);
      set_all(8'h00, 1'b0); tick();
      chk("still_ila", 32'(ILA_EN), 32'h1);

      // Reset mid-ILA
      RST = 1'b1; tick(); RST = 1'b0;
      chk_out("mid_ila_rst", 1'b0, 1'b0, 1'b0, 4'h0);
      set_all(K_CH, 1'b1);
      tick(); tick(); tick(); chk("recover_k3", 32'(LANE_SYNCED), 32'h0);
      tick(); chk("recover_k4", 32'(LANE_SYNCED), 32'hF);
      LMFC_ME = 1'b1; tick(); LMFC_ME = 1'b0;
      chk_out("ila_entry2", 1'b1, 1'b1, 1'b0, 4'hF);

      // ILA again: lane 3 completes last
      set_all(R_CH, 1'b1); tick();
      set_all(A_CH, 1'b1); tick(); tick(); tick();
      set_lane(3, 8'h00, 1'b0); tick();
      chk_out("lane3_pending", 1'b1, 1'b1, 1'b0, 4'hF);
      set_all(8'h00, 1'b0); set_lane(3, A_CH, 1'b1); tick();
      chk_out("data_entry", 1'b1, 1'b0, 1'b1, 4'hF);

      // DATA: spaced errors on lane 1 are forgiven
      set_all(8'h00, 1'b0);
      RX_ERR[1] = 1'b1; tick(); RX_ERR[1] = 1'b0;
      tick(); tick(); tick(); tick();
      RX_ERR[1] = 1'b1; tick(); RX_ERR[1] = 1'b0;
      chk_out("err_spaced", 1'b1, 1'b0, 1'b1, 4'hF);
      tick(); tick(); tick(); tick();

      // Errors at c, c+2, c+4 drop lane 1 and the link
      RX_ERR[1] = 1'b1; tick(); RX_ERR[1] = 1'b0; tick();
      RX_ERR[1] = 1'b1; tick(); RX_ERR[1] = 1'b0;
      chk("err_two", 32'(DATA_EN), 32'h1);
      tick();
      RX_ERR[1] = 1'b1; tick(); RX_ERR[1] = 1'b0;
      chk_out("err_three", 1'b0, 1'b0, 1'b0, 4'hD);

      // Resync, then lane 0 never sends /R/
      set_all(K_CH, 1'b1);
      tick(); tick(); tick(); tick();
      chk("resync", 32'(LANE_SYNCED), 32'hF);
      LMFC_ME = 1'b1; tick(); LMFC_ME = 1'b0;
      chk("ila_entry3", 32'(ILA_EN), 32'h1);
      set_all(R_CH, 1'b1); set_lane(0, A_CH, 1'b1); tick();
      set_all(A_CH, 1'b1); tick(); tick(); tick(); tick();
      chk("lane0_blocks", 32'(ILA_EN), 32'h1);
      for (int p = 1; p <= 8; p++) begin
         LMFC_ME = 1'b1; tick(); LMFC_ME = 1'b0;
         if (p == 7) chk_out("lmfc7", 1'b1, 1'b1, 1'b0, 4'hF);
         if (p < 8) begin tick(); tick(); end
      end
`ifdef RX_CU_ILA_TIMEOUT_EN
      chk_out("ila_timeout", 1'b0, 1'b0, 1'b0, 4'hF);
`else
      chk_out("ila_waits", 1'b1, 1'b1, 1'b0, 4'hF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
